vliw_sequencer: RTL and testbench
=================================

Name: vliw_sequencer

Overview:
- Upstream instruction source for mtx_unit.
- Holds a host-loaded program of control-tagged VLIW bundles and issues at most one bundle per cycle on vliw_inst.
- Supports counted, nestable hardware loops, a wait-for-sync op and halt, so mtx_unit and shared_memory run a program without per-cycle host driving.

Parameters:
IMEM_DEPTH, 256, program words; power of two; PC width AW = $clog2(IMEM_DEPTH)
LOOP_DEPTH, 4, hardware loop stack entries
CNT_W, 16, loop count / immediate width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
prog_we  in  1  host program write strobe; ignored while busy
prog_addr  in  AW  host write address
prog_wdata  in  seq_word_t  {ctrl op, imm[CNT_W], vliw_inst_t bundle}
start  in  1  single-cycle pulse; begin at PC 0; ignored while busy
stall  in  1  downstream not ready; holds issue
sync_in  in  1  external event that releases WAITS
vliw_inst  out  vliw_inst_t  bundle to mtx_unit; all-NOP when not issuing
inst_valid  out  1  vliw_inst carries a program bundle this cycle
busy  out  1  program running
done  out  1  one-cycle pulse on HALT retire
err  out  1  sticky error flag; cleared by start
pc  out  AW  PC of the bundle currently presented

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; vliw_inst='0 (all NOP, NOP encodes as 0); inst_valid=0; busy=0; done=0; err=0; pc=0; loop stack empty. IMEM contents are not reset.
- Reset mid-program aborts immediately; no done pulse.
- IMEM: single write port (host), synchronous read with 1-cycle latency. Writes apply only in IDLE.
- States:
  - IDLE: on start, go to FETCH. pc=0, err cleared, stack cleared, busy=1.
  - FETCH: one bubble while word 0 is read; then RUN.
  - RUN: present the fetched word. Bundle issued (inst_valid=1) iff stall=0; then apply the ctrl op.
  - WAIT: NOP issued until sync_in=1; then the next word is issued the following cycle.
  - IDLE is re-entered after HALT or an error.
- Ctrl ops (seq_op_t):
  - SEQ: pc+1.
  - LOOP: push {start=pc+1, count=max(imm,1)}; issue the bundle; pc+1.
  - ENDL: issue the bundle. If top.count>1, decrement and jump to top.start, costing 1 NOP bubble cycle. Otherwise pop and go to pc+1.
  - WAITS: issue the bundle; pc+1; go to WAIT unless sync_in=1 in the same cycle.
  - HALT: issue the bundle; pulse done; busy=0; go to IDLE.
- Throughput: straight-line code issues 1 bundle per cycle. A taken loop-back costs 1 cycle. Latency from start to first bundle is 2 cycles.
- Stall: while stall=1, vliw_inst is all-NOP, inst_valid=0, and pc and stack are frozen. The held bundle is issued exactly once, in the first cycle stall=0. No bundle is ever issued twice.
- Errors (set err, output NOP, go to IDLE, no done):
  - LOOP with stack full;
  - ENDL with stack empty;
  - SEQ/LOOP/WAITS at pc=IMEM_DEPTH-1 (no wrap);
  - an undefined ctrl encoding.
  - The offending word's bundle is not issued.
- start and stall in the same cycle: start is accepted; stall applies from RUN onward.

Decomposition:
- mtx_types gains:
  - seq_op_t enum (SEQ=0, LOOP, ENDL, WAITS, HALT);
  - seq_word_t packed struct {seq_op_t op; logic [CNT_W-1:0] imm; vliw_inst_t bundle};
  - LOOP_DEPTH default constant.
- One sub-module: seq_loop_stack (push/pop/decrement-top, full/empty flags).
- IMEM is an inferred array inside vliw_sequencer.

Test Plan:
- Straight line: load {SEQ LD_V0},{SEQ LD_M0},{SEQ MVMUL},{HALT PUSH_V0}; start -> bundles on cycles 2..5 with inst_valid=1; done pulses in cycle 5; busy falls in cycle 6.
- Loop:
  - program: word1 {LOOP imm=3, MVMUL}, word2 {ENDL, VRELU}.
  - expected: MVMUL issued once; VRELU issued 3 times, each taken back-jump followed by 1 NOP bubble; pc sequence 1,2,·,2,·,2,3.
  - nested 2x2 loops: inner body issued 4 times.
- Stall: assert stall for 3 cycles while MVMUL is presented -> 3 NOP cycles; MVMUL issued exactly once after release; pc unchanged during stall.
- WAITS: {WAITS POP_V1} followed by {HALT NOP}; hold sync_in=0 for 5 cycles -> POP_V1 issued once, then 5 NOPs, then HALT bundle in the cycle after sync_in=1.
- Errors:
  - ENDL first -> err=1, no done, no bundle issued.
  - LOOP depth 5 -> err=1.
  - the next start clears err.
- Reset mid-loop: drop rst_n while in RUN -> outputs at reset values immediately; the following start runs from pc=0 with an empty stack.

Source files
------------

// File: rtl/mtx_types.sv
// rtl/mtx_types.sv - shared mtx_unit bundle types and sequencer program word types
package mtx_types;

    localparam int SEQ_IMEM_DEPTH = 256;
    localparam int SEQ_LOOP_DEPTH = 4;
    localparam int SEQ_CNT_W      = 16;

    typedef enum logic [3:0] {
        NOP     = 4'd0,
        LD_V0   = 4'd1,
        LD_V1   = 4'd2,
        LD_M0   = 4'd3,
        MVMUL   = 4'd4,
        VRELU   = 4'd5,
        PUSH_V0 = 4'd6,
        POP_V1  = 4'd7
    } mtx_op_t;

    typedef struct packed {
        mtx_op_t    op;
        logic [3:0] dst;
        logic [7:0] addr;
    } vliw_inst_t;

    typedef enum logic [2:0] {
        SEQ   = 3'd0,
        LOOP  = 3'd1,
        ENDL  = 3'd2,
        WAITS = 3'd3,
        HALT  = 3'd4
    } seq_op_t;

    typedef struct packed {
        seq_op_t                op;
        logic [SEQ_CNT_W-1:0]   imm;
        vliw_inst_t             bundle;
    } seq_word_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RUN   = 2'd2,
        S_WAIT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/vliw_sequencer_loop_stack.sv
// rtl/vliw_sequencer_loop_stack.sv - hardware loop stack of {start pc, remaining count}
module seq_loop_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic             dec,
    input  logic [AW-1:0]    push_start,
    input  logic [CNT_W-1:0] push_count,
    output logic [AW-1:0]    top_start,
    output logic [CNT_W-1:0] top_count,
    output logic             full,
    output logic             empty
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPW-1:0]   sp;
    logic [AW-1:0]    start_mem [DEPTH];
    logic [CNT_W-1:0] cnt_mem   [DEPTH];
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    wr_idx;

    assign top_idx   = IW'(sp - SPW'(1));
    assign wr_idx    = IW'(sp);
    assign full      = (sp == SPW'(DEPTH));
    assign empty     = (sp == '0);
    assign top_start = start_mem[top_idx];
    assign top_count = cnt_mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

    // Entries need no reset: nothing is read past sp.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            start_mem[wr_idx] <= push_start;
            cnt_mem[wr_idx]   <= push_count;
        end else if (dec && !empty) begin
            cnt_mem[top_idx]  <= top_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/vliw_sequencer.sv
// rtl/vliw_sequencer.sv - program sequencer issuing one VLIW bundle per cycle to mtx_unit
module vliw_sequencer
    import mtx_types::*;
#(
    parameter int IMEM_DEPTH = SEQ_IMEM_DEPTH,
    parameter int LOOP_DEPTH = SEQ_LOOP_DEPTH,
    parameter int CNT_W      = SEQ_CNT_W,
    localparam int AW        = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  seq_word_t     prog_wdata,
    input  logic          start,
    input  logic          stall,
    input  logic          sync_in,
    output vliw_inst_t    vliw_inst,
    output logic          inst_valid,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] pc
);
    seq_word_t        imem [IMEM_DEPTH];
    seq_word_t        rd_word;
    seq_state_t       state;
    logic [AW-1:0]    pc_next;
    logic             at_last;
    logic             bad;
    logic             issue;
    logic             taken;
    logic [CNT_W-1:0] loop_count;
    logic [AW-1:0]    top_start;
    logic [CNT_W-1:0] top_count;
    logic             stk_full;
    logic             stk_empty;

    always_comb begin
        at_last = (pc == AW'(IMEM_DEPTH - 1));
        case (rd_word.op)
            SEQ, WAITS: bad = at_last;
            LOOP:       bad = at_last || stk_full;
            ENDL:       bad = stk_empty;
            HALT:       bad = 1'b0;
            default:    bad = 1'b1;
        endcase
        issue = (state == S_RUN) && !stall && !bad;
        taken = issue && (rd_word.op == ENDL) && (top_count > CNT_W'(1));
        // The read address is always the next pc so straight-line code needs no bubble.
        pc_next = pc;
        if (state == S_IDLE && start) begin
            pc_next = '0;
        end else if (issue && rd_word.op != HALT) begin
            pc_next = taken ? top_start : pc + AW'(1);
        end
        loop_count = (rd_word.imm == '0) ? CNT_W'(1) : CNT_W'(rd_word.imm);
    end

    assign vliw_inst  = issue ? rd_word.bundle : '0;
    assign inst_valid = issue;
    assign done       = issue && (rd_word.op == HALT);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (state == S_IDLE && prog_we) begin
            imem[prog_addr] <= prog_wdata;
        end
        rd_word <= imem[pc_next];
    end

    seq_loop_stack #(
        .DEPTH (LOOP_DEPTH),
        .AW    (AW),
        .CNT_W (CNT_W)
    ) u_loop_stack (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == S_IDLE && start),
        .push       (issue && rd_word.op == LOOP),
        .pop        (issue && rd_word.op == ENDL && !taken),
        .dec        (taken),
        .push_start (pc + AW'(1)),
        .push_count (loop_count),
        .top_start  (top_start),
        .top_count  (top_count),
        .full       (stk_full),
        .empty      (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            err   <= 1'b0;
        end else begin
            pc <= pc_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        err   <= 1'b0;
                    end
                end
                S_FETCH: state <= S_RUN;
                S_RUN: begin
                    if (!stall) begin
                        if (bad) begin
                            state <= S_IDLE;
                            err   <= 1'b1;
                        end else if (taken) begin
                            state <= S_FETCH;
                        end else if (rd_word.op == WAITS && !sync_in) begin
                            state <= S_WAIT;
                        end else if (rd_word.op == HALT) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_WAIT: begin
                    if (sync_in) state <= S_RUN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vliw_sequencer.sv
// tb/tb_vliw_sequencer.sv - self-checking bench for vliw_sequencer
module tb_vliw_sequencer;
    import mtx_types::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_we;
    logic [7:0] prog_addr;
    seq_word_t  prog_wdata;
    logic       start, stall, sync_in;
    vliw_inst_t vliw_inst;
    logic       inst_valid, busy, done, err;
    logic [7:0] pc;

    int checks = 0;
    int errors = 0;

    seq_word_t  mem [256];
    vliw_inst_t exp_q [$];
    vliw_inst_t obs_q [$];

    always #5 clk = ~clk;

    vliw_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .start      (start),
        .stall      (stall),
        .sync_in    (sync_in),
        .vliw_inst  (vliw_inst),
        .inst_valid (inst_valid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pc         (pc)
    );

    function automatic seq_word_t mk(input seq_op_t op, input int imm, input mtx_op_t mop);
        seq_word_t w;
        w.op          = op;
        w.imm         = 16'(imm);
        w.bundle.op   = mop;
        w.bundle.dst  = 4'($urandom_range(0, 15));
        w.bundle.addr = 8'($urandom_range(0, 255));
        return w;
    endfunction

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            prog_we    = 1'b1;
            prog_addr  = 8'(i);
            prog_wdata = mem[i];
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
    endtask

    task automatic set_straight();
        mem[0] = mk(SEQ, 0, LD_V0);
        mem[1] = mk(SEQ, 0, LD_M0);
        mem[2] = mk(SEQ, 0, MVMUL);
        mem[3] = mk(HALT, 0, PUSH_V0);
        load(4);
    endtask

    // Program interpreter: the bundles a correct sequencer issues, in order, and whether it faults.
    task automatic model_run(output bit m_err);
        int pc_m = 0;
        int lstart [$];
        int lcnt [$];
        seq_word_t w;
        exp_q.delete();
        m_err = 1'b0;
        for (int g = 0; g < 4000; g++) begin
            w = mem[pc_m];
            if (w.op == HALT) begin
                exp_q.push_back(w.bundle);
                return;
            end else if (w.op == SEQ || w.op == WAITS) begin
                if (pc_m == 255) begin m_err = 1'b1; return; end
                exp_q.push_back(w.bundle);
                pc_m++;
            end else if (w.op == LOOP) begin
                if (pc_m == 255 || lstart.size() == 4) begin m_err = 1'b1; return; end
                exp_q.push_back(w.bundle);
                lstart.push_back(pc_m + 1);
                lcnt.push_back(w.imm == 0 ? 1 : int'(w.imm));
                pc_m++;
            end else if (w.op == ENDL) begin
                if (lstart.size() == 0) begin m_err = 1'b1; return; end
                exp_q.push_back(w.bundle);
                if (lcnt[lcnt.size()-1] > 1) begin
                    lcnt[lcnt.size()-1] = lcnt[lcnt.size()-1] - 1;
                    pc_m = lstart[lstart.size()-1];
                end else begin
                    void'(lstart.pop_back());
                    void'(lcnt.pop_back());
                    pc_m++;
                end
            end else begin
                m_err = 1'b1;
                return;
            end
        end
    endtask

    // Runs the loaded program from start until busy falls; only collects observations.
    task automatic run_prog(input int max_cyc, input bit rnd, output int ndone,
                            output bit fin, output bit fin_err, output bit cyc1_err);
        obs_q.delete();
        ndone = 0; fin = 1'b0; fin_err = 1'b0; cyc1_err = 1'b1;
        for (int c = 0; c < max_cyc && !fin; c++) begin
            start   = (c == 0);
            stall   = rnd && (c > 0) && ($urandom_range(0, 3) == 0);
            sync_in = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
            @(negedge clk);
            if (inst_valid) obs_q.push_back(vliw_inst);
            if (done) ndone++;
            if (c == 1) cyc1_err = err;
            if (c >= 1 && !busy) begin fin = 1'b1; fin_err = err; end
            @(posedge clk); #1;
        end
        start = 1'b0; stall = 1'b0; sync_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        start = 1'b0; stall = 1'b0; sync_in = 1'b0;
        #3;
        checks++;
        if ({vliw_inst, inst_valid, busy, done, err, pc} !== '0)
            $display("FAIL reset_outputs: got inst=%0h v=%0b busy=%0b done=%0b err=%0b pc=%0d, expected all zero",
                     vliw_inst, inst_valid, busy, done, err, pc);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_straight();
        bit exp_v;
        set_straight();
        for (int c = 0; c < 7; c++) begin
            start = (c == 0);
            @(negedge clk);
            exp_v = (c >= 2 && c <= 5);
            checks++;
            if (inst_valid !== exp_v || busy !== (c >= 1 && c <= 5) || done !== (c == 5)) begin
                errors++;
                $display("FAIL straight_ctl c=%0d: got v=%0b busy=%0b done=%0b", c, inst_valid, busy, done);
            end
            checks++;
            if (exp_v) begin
                if (vliw_inst !== mem[c-2].bundle || pc !== 8'(c-2)) begin
                    errors++;
                    $display("FAIL straight_bundle c=%0d: got %0h pc=%0d, expected %0h pc=%0d",
                             c, vliw_inst, pc, mem[c-2].bundle, c-2);
                end
            end else if (vliw_inst !== '0) begin
                errors++;
                $display("FAIL straight_nop c=%0d: got %0h, expected 0", c, vliw_inst);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_loop();
        int e_tab [8];
        int e;
        e_tab = '{0, 1, 2, -1, 2, -1, 2, 3};
        mem[0] = mk(SEQ, 0, LD_V0);
        mem[1] = mk(LOOP, 3, MVMUL);
        mem[2] = mk(ENDL, 0, VRELU);
        mem[3] = mk(HALT, 0, NOP);
        load(4);
        for (int c = 0; c < 11; c++) begin
            start = (c == 0);
            @(negedge clk);
            e = (c >= 2 && c <= 9) ? e_tab[c-2] : -1;
            checks++;
            if (inst_valid !== (e >= 0) || done !== (c == 9)) begin
                errors++;
                $display("FAIL loop_valid c=%0d: got v=%0b done=%0b, expected v=%0b done=%0b",
                         c, inst_valid, done, e >= 0, c == 9);
            end else if (e >= 0 && (pc !== 8'(e) || vliw_inst !== mem[e].bundle)) begin
                errors++;
                $display("FAIL loop_bundle c=%0d: got pc=%0d %0h, expected pc=%0d %0h",
                         c, pc, vliw_inst, e, mem[e].bundle);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_nested();
        int nd, nmv;
        bit f, fe, c1e, me;
        mem[0] = mk(LOOP, 2, LD_V0);
        mem[1] = mk(LOOP, 2, LD_M0);
        mem[2] = mk(ENDL, 0, MVMUL);
        mem[3] = mk(ENDL, 0, VRELU);
        mem[4] = mk(HALT, 0, NOP);
        load(5);
        run_prog(100, 1'b0, nd, f, fe, c1e);
        model_run(me);
        nmv = 0;
        foreach (obs_q[i]) if (obs_q[i].op == MVMUL) nmv++;
        checks++;
        if (nmv !== 4) begin
            errors++;
            $display("FAIL nested_inner_count: got %0d, expected 4", nmv);
        end
        checks++;
        if (obs_q != exp_q || nd !== 1 || fe !== 1'b0 || !f) begin
            errors++;
            $display("FAIL nested_trace: got n=%0d done=%0d err=%0b, expected n=%0d done=1 err=0",
                     obs_q.size(), nd, fe, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int e_tab [10];
        int e;
        set_straight();
        e_tab = '{-1, -1, 0, 1, -2, -2, -2, 2, 3, -1};
        for (int c = 0; c < 10; c++) begin
            start = (c == 0);
            stall = (c >= 4 && c <= 6);
            @(negedge clk);
            e = e_tab[c];
            checks++;
            if (inst_valid !== (e >= 0) || done !== (c == 8)) begin
                errors++;
                $display("FAIL stall_valid c=%0d: got v=%0b done=%0b", c, inst_valid, done);
            end else if (e >= 0 && vliw_inst !== mem[e].bundle) begin
                errors++;
                $display("FAIL stall_bundle c=%0d: got %0h, expected %0h", c, vliw_inst, mem[e].bundle);
            end else if (e == -2 && (pc !== 8'd2 || vliw_inst !== '0)) begin
                errors++;
                $display("FAIL stall_hold c=%0d: got pc=%0d inst=%0h, expected pc=2 inst=0", c, pc, vliw_inst);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; stall = 1'b0;
    endtask

    task automatic test_waits();
        mem[0] = mk(WAITS, 0, POP_V1);
        mem[1] = mk(HALT, 0, NOP);
        load(2);
        for (int c = 0; c < 11; c++) begin
            start   = (c == 0);
            sync_in = (c == 8);
            @(negedge clk);
            checks++;
            if (inst_valid !== (c == 2 || c == 9) || done !== (c == 9) || busy !== (c >= 1 && c <= 9)) begin
                errors++;
                $display("FAIL waits_ctl c=%0d: got v=%0b done=%0b busy=%0b", c, inst_valid, done, busy);
            end else if (c == 2 && vliw_inst !== mem[0].bundle) begin
                errors++;
                $display("FAIL waits_bundle: got %0h, expected %0h", vliw_inst, mem[0].bundle);
            end else if (c == 9 && (vliw_inst !== mem[1].bundle || pc !== 8'd1)) begin
                errors++;
                $display("FAIL waits_halt: got %0h pc=%0d, expected %0h pc=1", vliw_inst, pc, mem[1].bundle);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; sync_in = 1'b0;
    endtask

    task automatic test_errors();
        int nd, n;
        bit f, fe, c1e, me;
        for (int p = 0; p < 3; p++) begin
            if (p == 0) begin
                mem[0] = mk(ENDL, 0, VRELU);
                mem[1] = mk(HALT, 0, NOP);
                n = 2;
            end else if (p == 1) begin
                for (int i = 0; i < 5; i++) mem[i] = mk(LOOP, 1, LD_V0);
                for (int i = 5; i < 10; i++) mem[i] = mk(ENDL, 0, VRELU);
                mem[10] = mk(HALT, 0, NOP);
                n = 11;
            end else begin
                mem[0] = mk(SEQ, 0, LD_V1);
                mem[1] = mk(seq_op_t'(3'd6), 0, MVMUL);
                mem[2] = mk(HALT, 0, NOP);
                n = 3;
            end
            load(n);
            run_prog(60, 1'b0, nd, f, fe, c1e);
            model_run(me);
            checks++;
            if (!f || fe !== 1'b1 || nd !== 0 || obs_q != exp_q || !me) begin
                errors++;
                $display("FAIL error_prog%0d: got fin=%0b err=%0b done=%0d issued=%0d, expected err=1 done=0 issued=%0d",
                         p, f, fe, nd, obs_q.size(), exp_q.size());
            end
            checks++;
            @(negedge clk);
            if (err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL error_sticky%0d: got err=%0b busy=%0b, expected 1 0", p, err, busy);
            end
            @(posedge clk); #1;
        end
        set_straight();
        run_prog(30, 1'b0, nd, f, fe, c1e);
        checks++;
        if (c1e !== 1'b0 || fe !== 1'b0 || nd !== 1) begin
            errors++;
            $display("FAIL error_clear: got err@1=%0b err_end=%0b done=%0d, expected 0 0 1", c1e, fe, nd);
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        bit f, fe, c1e, me;
        for (int i = 0; i < 4; i++) mem[i] = mk(LOOP, 2, mtx_op_t'(i + 1));
        for (int i = 4; i < 8; i++) mem[i] = mk(ENDL, 0, VRELU);
        mem[8] = mk(HALT, 0, NOP);
        load(9);
        for (int c = 0; c < 6; c++) begin
            start = (c == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vliw_inst, inst_valid, busy, done, err, pc} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got inst=%0h v=%0b busy=%0b done=%0b err=%0b pc=%0d, expected all zero",
                     vliw_inst, inst_valid, busy, done, err, pc);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        run_prog(200, 1'b0, nd, f, fe, c1e);
        model_run(me);
        checks++;
        if (!f || fe !== 1'b0 || nd !== 1 || obs_q != exp_q || me) begin
            errors++;
            $display("FAIL reset_rerun: got fin=%0b err=%0b done=%0d issued=%0d, expected err=0 done=1 issued=%0d",
                     f, fe, nd, obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        int nd, n, kind, body;
        bit f, fe, c1e, me;
        for (int it = 0; it < 25; it++) begin
            n = 0;
            for (int b = 0; b < int'($urandom_range(1, 5)); b++) begin
                kind = $urandom_range(0, 2);
                if (kind == 0) begin
                    mem[n] = mk(SEQ, 0, mtx_op_t'($urandom_range(0, 7))); n++;
                end else if (kind == 1) begin
                    mem[n] = mk(WAITS, 0, mtx_op_t'($urandom_range(0, 7))); n++;
                end else begin
                    mem[n] = mk(LOOP, $urandom_range(0, 3), mtx_op_t'($urandom_range(0, 7))); n++;
                    body = $urandom_range(0, 2);
                    for (int k = 0; k < body; k++) begin
                        mem[n] = mk(SEQ, 0, mtx_op_t'($urandom_range(0, 7))); n++;
                    end
                    mem[n] = mk(ENDL, 0, mtx_op_t'($urandom_range(0, 7))); n++;
                end
            end
            mem[n] = mk(HALT, 0, mtx_op_t'($urandom_range(0, 7))); n++;
            load(n);
            run_prog(600, 1'b1, nd, f, fe, c1e);
            model_run(me);
            checks++;
            if (!f || fe !== me || nd !== 1 || obs_q != exp_q) begin
                errors++;
                $display("FAIL random_it%0d: got fin=%0b err=%0b done=%0d issued=%0d, expected err=%0b done=1 issued=%0d",
                         it, f, fe, nd, obs_q.size(), me, exp_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_loop();
        test_nested();
        test_stall();
        test_waits();
        test_errors();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
